apb_cmd_master: RTL and testbench

- Fabric-side APB3 initiator. It drains a small command FIFO of register reads and writes and issues each one as an APB3 transfer onto a CoreAPB3 slave-side bus.
- Lets fabric logic (e.g. a G-code/segment sequencer) program stepper_control and other APB peripherals without going through the MSS.
- Returns one response per command: read data, slave error flag and timeout flag.

---
 rtl/apb_cmd_master.sv | 132 +++++++++++++
 tb/tb_apb_cmd_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 initiator fed by a small command FIFO of register reads/writes.
// One response (read data, slave error, timeout) is produced per command, in order.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    // Counter only needs to reach TIMEOUT-1; a zero TIMEOUT leaves it free-running and unused.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t            state_reg;
    logic [CMD_W-1:0]  mem [DEPTH];
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic [CNT_W-1:0]  tmo_cnt_reg;
    logic [CMD_W-1:0]  head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Full when the pointers differ only in the wrap bit.
    assign full      = (wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {PTR_W{1'b0}}};
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_reg == IDLE) && !empty;
    assign busy      = !empty || (state_reg != IDLE);
    assign head      = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            tmo_cnt_reg <= '0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        {PWRITE, PADDR, PWDATA} <= head;
                        PSEL      <= 1'b1;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE     <= 1'b1;
                    tmo_cnt_reg <= '0;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        if (TIMEOUT != 0 && tmo_cnt_reg == CNT_LAST) begin
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state_reg   <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a wait-state APB slave model and
// queue scoreboards for bus transfers and responses.
module tb_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    // Slave model controls
    logic        slave_hold;
    logic [7:0]  slave_wait;
    logic        slave_err;
    logic        noise_err;
    logic [7:0]  wcnt;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    bus_t mb;
    rsp_t mr;

    int checks   = 0;
    int failures = 0;
    int rsp_n    = 0;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_wr;
    logic        prev_rsp = 1'b0;

    apb_cmd_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (4),
        .TIMEOUT(8)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'h8AFB0005;
    endfunction

    // Slave: inserts slave_wait wait states, or stalls forever while slave_hold=1.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) wcnt <= '0;
        else if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 8'd1;
        else wcnt <= '0;
    end
    assign PREADY  = PSEL && PENABLE && !slave_hold && (wcnt >= slave_wait);
    assign PRDATA  = slave_data(PADDR);
    assign PSLVERR = PREADY ? slave_err : noise_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd_exp, input logic err, input logic to);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk("push_accept_bound", 32'(n >= 200), 32'd0);
        bus_q.push_back('{wr, a, d});
        rsp_q.push_back('{rd_exp, err, to});
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((rsp_q.size() != 0 || busy) && n < 300) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk(tag, 32'(n >= 300), 32'd0);
    endtask

    // Counts PENABLE cycles until the response pulse, returned in cnt.
    task automatic count_enable(output int cnt);
        int n = 0;
        cnt = 0;
        while (!rsp_valid && n < 100) begin
            if (PENABLE) cnt++;
            @(posedge PCLK); #1;
            n++;
        end
        chk("rsp_wait_bound", 32'(n >= 100), 32'd0);
    endtask

    // Monitor: checks each SETUP against the bus queue and each response against the response queue.
    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_rsp = 1'b0;
        end else begin
            if (PSEL && !PENABLE) begin
                chk("setup_pending", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    mb = bus_q.pop_front();
                    chk("paddr", PADDR, mb.addr);
                    chk("pwrite", 32'(PWRITE), 32'(mb.wr));
                    if (mb.wr) chk("pwdata", PWDATA, mb.wdata);
                    cur_addr  = PADDR;
                    cur_wdata = PWDATA;
                    cur_wr    = PWRITE;
                end
            end
            if (PSEL && PENABLE) begin
                chk("paddr_stable", PADDR, cur_addr);
                chk("pwdata_stable", PWDATA, cur_wdata);
                chk("pwrite_stable", 32'(PWRITE), 32'(cur_wr));
            end
            if (rsp_valid) begin
                rsp_n++;
                chk("rsp_pulse", 32'(prev_rsp), 32'd0);
                chk("rsp_pending", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    mr = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mr.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(mr.err));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(mr.to));
                end
                $display("rsp %0d: rdata=%h err=%0b timeout=%0b", rsp_n, rsp_rdata, rsp_err, rsp_timeout);
            end
            prev_rsp = rsp_valid;
        end
    end

    initial begin
        int en_cycles;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        slave_hold = 1'b0;
        slave_wait = 8'd0;
        slave_err  = 1'b0;
        noise_err  = 1'b0;
        PRESET     = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Single zero-wait write: latency N+1 / N+2 / N+3
        push(1'b1, 32'h40050000, 32'h000001F4, 32'd0, 1'b0, 1'b0);
        chk("wr_psel_n0", 32'(PSEL), 32'd0);
        @(posedge PCLK); #1;
        chk("wr_psel_n1", 32'(PSEL), 32'd1);
        chk("wr_penable_n1", 32'(PENABLE), 32'd0);
        @(posedge PCLK); #1;
        chk("wr_penable_n2", 32'(PENABLE), 32'd1);
        chk("wr_pwdata_n2", PWDATA, 32'h000001F4);
        @(posedge PCLK); #1;
        chk("wr_rsp_valid_n3", 32'(rsp_valid), 32'd1);
        chk("wr_psel_n3", 32'(PSEL), 32'd0);
        @(posedge PCLK); #1;
        chk("wr_rsp_valid_n4", 32'(rsp_valid), 32'd0);
        drain("drain_wr");

        // Read with 3 wait states; PSLVERR toggled during waits must be ignored
        slave_wait = 8'd3;
        noise_err  = 1'b1;
        push(1'b0, 32'h40050004, 32'd0, 32'hCAFE0001, 1'b0, 1'b0);
        count_enable(en_cycles);
        chk("rd_penable_cycles", 32'(en_cycles), 32'd4);
        drain("drain_rd");
        slave_wait = 8'd0;
        noise_err  = 1'b0;

        // FIFO fill: one on the bus, four queued, sixth held off
        slave_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(i[0] == 1'b0, 32'h40000100 + 32'(i * 4), 32'h1000 + 32'(i),
                 (i[0] == 1'b0) ? 32'd0 : slave_data(32'h40000100 + 32'(i * 4)), 1'b0, 1'b0);
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40000114;
        repeat (2) @(posedge PCLK);
        #1;
        chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_penable", 32'(PENABLE), 32'd1);
        slave_hold = 1'b0;
        push(1'b0, 32'h40000114, 32'd0, slave_data(32'h40000114), 1'b0, 1'b0);
        drain("drain_fill");

        // Slave error, then a normal read
        slave_err = 1'b1;
        push(1'b1, 32'h40050008, 32'h0000DEAD, 32'd0, 1'b1, 1'b0);
        drain("drain_slverr");
        slave_err = 1'b0;
        push(1'b0, 32'h4005000C, 32'd0, slave_data(32'h4005000C), 1'b0, 1'b0);
        drain("drain_after_err");

        // Timeout after 8 ACCESS cycles
        slave_hold = 1'b1;
        push(1'b0, 32'h40050010, 32'd0, 32'd0, 1'b1, 1'b1);
        count_enable(en_cycles);
        chk("to_penable_cycles", 32'(en_cycles), 32'd8);
        chk("to_busy", 32'(busy), 32'd0);
        slave_hold = 1'b0;
        drain("drain_to");

        // Reset during ACCESS with two commands queued
        slave_hold = 1'b1;
        push(1'b1, 32'h40050014, 32'h11, 32'd0, 1'b0, 1'b0);
        push(1'b1, 32'h40050018, 32'h22, 32'd0, 1'b0, 1'b0);
        push(1'b1, 32'h4005001C, 32'h33, 32'd0, 1'b0, 1'b0);
        chk("rstmid_penable", 32'(PENABLE), 32'd1);
        #2;
        bus_q.delete();
        rsp_q.delete();
        PRESET = 1'b1;
        #1;
        chk("rstmid_psel", 32'(PSEL), 32'd0);
        chk("rstmid_penable_low", 32'(PENABLE), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge PCLK);
        #1;
        PRESET     = 1'b0;
        slave_hold = 1'b0;
        repeat (10) @(posedge PCLK);
        #1;
        chk("post_rst_psel", 32'(PSEL), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        push(1'b1, 32'h40050020, 32'h55, 32'd0, 1'b0, 1'b0);
        drain("drain_post_rst");

        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
